// File: rtl/ky32_rr_arbiter8_pkg.sv
// Shared definitions for the KY32 8-way round-robin arbiter.
package ky32_rr_arbiter8_pkg;

  // Number of requesters sharing the resource and width of an owner index
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage : ky32_rr_arbiter8_pkg

// File: rtl/ky32_rr_arbiter8_decoder3x8.sv
// KY32 3x8 enabled decoder: one-hot of n when ena is high, all zeros otherwise.
module ky32_rr_arbiter8_decoder3x8
  import ky32_rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0] n,
  input  logic             ena,
  output logic [N_REQ-1:0] out
);

  // Decode the index into a single hot line, gated by the enable
  always_comb begin
    out = {N_REQ{1'b0}};
    if (ena) begin
      out[n] = 1'b1;
    end else begin
      out = {N_REQ{1'b0}};
    end
  end

endmodule : ky32_rr_arbiter8_decoder3x8

// File: rtl/ky32_rr_arbiter8.sv
// 8-way round-robin arbiter with hold-limit watchdog for one shared KY32 resource.
// A grant lives in OWN until the owner drops its request or the watchdog fires;
// RELEASE then inserts one dead cycle and rotates priority past the last owner.
module ky32_rr_arbiter8
  import ky32_rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_valid;
  logic             r_timeout;

  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_cand;
  logic             w_any;

  // Rotating priority search: first set request starting at r_ptr, wrapping mod 8.
  // Scanning from the far end down lets the closest candidate overwrite the rest.
  always_comb begin
    w_winner = {IDX_W{1'b0}};
    w_cand   = {IDX_W{1'b0}};
    w_any    = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = r_ptr + IDX_W'(k);
      if (req[w_cand]) begin
        w_winner = w_cand;
      end else begin
        w_winner = w_winner;
      end
    end
  end

  // Arbiter FSM: grant selection, hold counting, watchdog release and priority rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= {IDX_W{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_gnt_idx   <= {IDX_W{1'b0}};
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_OWN;
            r_gnt_idx   <= w_winner;
            r_gnt_valid <= 1'b1;
            r_cnt       <= CW'(1);
          end else begin
            r_state     <= ST_IDLE;
          end
        end
        ST_OWN: begin
          // A voluntary release wins over the watchdog in the same cycle
          if (!req[r_gnt_idx]) begin
            r_state     <= ST_RELEASE;
            r_gnt_valid <= 1'b0;
          end else if (r_cnt == CW'(MAX_HOLD)) begin
            r_state     <= ST_RELEASE;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          // Last owner becomes lowest priority for the next search
          r_ptr   <= r_gnt_idx + IDX_W'(1);
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  ky32_rr_arbiter8_decoder3x8 u_KY32_decoder3x8 (
    .n   (r_gnt_idx),
    .ena (r_gnt_valid),
    .out (gnt)
  );

  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule : ky32_rr_arbiter8

// File: tb/tb_ky32_rr_arbiter8.sv
// Self-checking bench for ky32_rr_arbiter8: directed vector table, round-robin
// sequence and randomized traffic against a behavioural ownership model.
module tb_ky32_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks;
  int n_errors;

  // Behavioural model: who owns the resource, for how long, and who went last
  int       m_owner;   // -1 when nobody owns
  int       m_held;
  bit       m_dead;    // turnaround cycle after a grant ends
  int       m_last;    // last owner; search starts just after it
  logic [2:0] m_idx;
  bit       m_to;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       to;
  } vec_t;

  vec_t vecs[28];

  ky32_rr_arbiter8 #(.MAX_HOLD(MAXH), .CW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge
  task automatic model_edge(input logic [7:0] r, input logic rs);
    bit found;
    int c;
    m_to = 1'b0;
    if (rs) begin
      m_owner = -1; m_held = 0; m_dead = 1'b0; m_last = 7; m_idx = 3'd0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_dead = 1'b1;
      end else if (m_held == MAXH) begin
        m_last = m_owner; m_owner = -1; m_dead = 1'b1; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (r != 8'h00) begin
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        c = (m_last + k) % 8;
        if (!found && r[c]) begin
          found = 1'b1;
          m_owner = c;
        end
      end
      m_held = 1;
      m_idx = m_owner[2:0];
    end
  endtask

  function automatic logic [12:0] model_outs();
    logic [7:0] g;
    g = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
    return {g, m_idx, (m_owner >= 0), m_to};
  endfunction

  // One clock: drive inputs, take the edge, then compare DUT against the model
  task automatic step(input logic [7:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    #1;
    model_edge(r, rs);
    check("model", {19'd0, gnt, gnt_idx, gnt_valid, timeout}, {19'd0, model_outs()});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    req = 8'h00;
    rst = 1'b1;
    m_owner = -1; m_held = 0; m_dead = 1'b0; m_last = 7; m_idx = 3'd0; m_to = 1'b0;

    // Reset, then ten idle cycles with no requests
    step(8'h00, 1'b1);
    check("reset_state", {gnt, gnt_idx, gnt_valid, timeout}, 13'd0);
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b0);
      check("idle_gnt", {gnt, gnt_valid}, 9'd0);
    end

    // Directed vectors: {rst, req, expected gnt, gnt_idx, gnt_valid, timeout}
    vecs[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h24, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h24, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h20, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h20, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h40, 8'h00, 3'd6, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h40, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[24] = '{1'b1, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 8'h30, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0};

    for (int i = 0; i < 28; i++) begin
      step(vecs[i].req, vecs[i].rst);
      check($sformatf("vec%0d", i),
            {19'd0, gnt, gnt_idx, gnt_valid, timeout},
            {19'd0, vecs[i].gnt, vecs[i].idx, vecs[i].v, vecs[i].to});
    end

    // All lines requesting, each owner holds two cycles: order 0,1..7,0
    step(8'h00, 1'b1);
    step(8'hFF, 1'b0);
    for (int g = 0; g < 9; g++) begin
      check($sformatf("rr_owner%0d", g), {28'd0, gnt_valid, gnt_idx},
            {28'd0, 1'b1, 3'(g % 8)});
      step(8'hFF, 1'b0);
      step(8'hFF & ~(8'd1 << (g % 8)), 1'b0);
      check("rr_gap_release", {31'd0, gnt_valid}, 32'd0);
      step(8'hFF, 1'b0);
      check("rr_gap_idle", {31'd0, gnt_valid}, 32'd0);
      step(8'hFF, 1'b0);
    end

    // Randomized traffic with sticky requests and occasional resets
    step(8'h00, 1'b1);
    begin
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 3000; i++) begin
        for (int b = 0; b < 8; b++) begin
          if (r[b]) begin
            if ($urandom_range(5, 0) == 0) r[b] = 1'b0;
          end else begin
            if ($urandom_range(3, 0) == 0) r[b] = 1'b1;
          end
        end
        step(r, ($urandom_range(299, 0) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ky32_rr_arbiter8
